// File: rtl/split_route_ctrl.sv
// Sequencer for a 1-to-2 CSP split: accepts 4-phase upstream flits, routes each packet
// by its head-flit destination, and issues paired data/select tokens to the split.
module split_route_ctrl #(
  parameter int                WIDTH   = 16,
  parameter int                ADDR_W  = 4,
  parameter logic [ADDR_W-1:0] MY_ADDR = '0,
  parameter int                CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_req,
  output logic             in_ack,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_req,
  input  logic             out_ack,
  output logic [WIDTH-1:0] out_data,
  output logic             sel_req,
  input  logic             sel_ack,
  output logic             sel_data,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1,
  output logic             drop_err,
  output logic             hdr_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: every channel is 4-phase. A req rises with its data already stable,
  // the receiver raises ack, req falls, then ack falls; data holds until that final fall.

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, RTZ = 2'd2, DROP = 2'd3} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic             oack_seen, sack_seen, pkt_open, route;
  logic             oack_seen_nx, sack_seen_nx, pkt_open_nx, route_nx;
  logic             in_ack_nx, out_req_nx, sel_req_nx, sel_data_nx;
  logic [WIDTH-1:0] out_data_nx;
  logic [CNT_W-1:0] pkt_cnt0_nx, pkt_cnt1_nx;
  logic             drop_err_nx, hdr_err_nx, busy_nx;

  logic in_head, dest_route, both_acked, rtz_done;

  assign in_head    = in_data[WIDTH-1];
  assign dest_route = (in_data[ADDR_W-1:0] != MY_ADDR);
  // Acks may arrive in different cycles; each is remembered once seen.
  assign both_acked = (oack_seen | out_ack) & (sack_seen | sel_ack);
  assign rtz_done   = !out_ack && !sel_ack && !in_req;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_req) state_nx = (in_head || pkt_open) ? SEND : DROP;
      SEND: if (both_acked) state_nx = RTZ;
      RTZ:  if (rtz_done) state_nx = IDLE;
      DROP: if (!in_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    oack_seen_nx = oack_seen;
    sack_seen_nx = sack_seen;
    pkt_open_nx  = pkt_open;
    route_nx     = route;
    in_ack_nx    = in_ack;
    out_req_nx   = out_req;
    sel_req_nx   = sel_req;
    sel_data_nx  = sel_data;
    out_data_nx  = out_data;
    pkt_cnt0_nx  = pkt_cnt0;
    pkt_cnt1_nx  = pkt_cnt1;
    drop_err_nx  = 1'b0;
    hdr_err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (in_req) begin
          if (in_head || pkt_open) begin
            out_data_nx  = in_data;
            out_req_nx   = 1'b1;
            sel_req_nx   = 1'b1;
            oack_seen_nx = 1'b0;
            sack_seen_nx = 1'b0;
            sel_data_nx  = route;
            if (in_head) begin
              route_nx    = dest_route;
              sel_data_nx = dest_route;
              hdr_err_nx  = pkt_open;
              pkt_open_nx = 1'b1;
            end
          end else begin
            in_ack_nx   = 1'b1;
            drop_err_nx = 1'b1;
          end
        end
      end
      SEND: begin
        oack_seen_nx = oack_seen | out_ack;
        sack_seen_nx = sack_seen | sel_ack;
        if (both_acked) begin
          out_req_nx = 1'b0;
          sel_req_nx = 1'b0;
          in_ack_nx  = 1'b1;
        end
      end
      RTZ: begin
        if (rtz_done) begin
          in_ack_nx = 1'b0;
          // A tail closes the packet; the count goes to the output it used.
          if (out_data[WIDTH-2]) begin
            pkt_open_nx = 1'b0;
            if (route) pkt_cnt1_nx = pkt_cnt1 + CNT_ONE;
            else       pkt_cnt0_nx = pkt_cnt0 + CNT_ONE;
          end
        end
      end
      DROP: if (!in_req) in_ack_nx = 1'b0;
      default: ;
    endcase
    busy_nx = (state_nx != IDLE) || pkt_open_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oack_seen <= 1'b0;
      sack_seen <= 1'b0;
      pkt_open  <= 1'b0;
      route     <= 1'b0;
      in_ack    <= 1'b0;
      out_req   <= 1'b0;
      sel_req   <= 1'b0;
      sel_data  <= 1'b0;
      out_data  <= '0;
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      drop_err  <= 1'b0;
      hdr_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      oack_seen <= oack_seen_nx;
      sack_seen <= sack_seen_nx;
      pkt_open  <= pkt_open_nx;
      route     <= route_nx;
      in_ack    <= in_ack_nx;
      out_req   <= out_req_nx;
      sel_req   <= sel_req_nx;
      sel_data  <= sel_data_nx;
      out_data  <= out_data_nx;
      pkt_cnt0  <= pkt_cnt0_nx;
      pkt_cnt1  <= pkt_cnt1_nx;
      drop_err  <= drop_err_nx;
      hdr_err   <= hdr_err_nx;
      busy      <= busy_nx;
    end
  end

endmodule

// File: tb/tb_split_route_ctrl.sv
// Directed bench for split_route_ctrl: drives upstream/split 4-phase handshakes and
// checks routing, counters, error pulses and reset behaviour against hand values.
module tb_split_route_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_req = 1'b0, out_ack = 1'b0, sel_ack = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ack, out_req, sel_req, sel_data, drop_err, hdr_err, busy;
  logic [15:0] out_data;
  logic [7:0]  pkt_cnt0, pkt_cnt1;
  logic [1:0]  dbg_state;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_q[$];

  split_route_ctrl dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
    .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
    .sel_req(sel_req), .sel_ack(sel_ack), .sel_data(sel_data),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_err(drop_err), .hdr_err(hdr_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_req = 1'b0; out_ack = 1'b0; sel_ack = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Driver: one routed flit through the full upstream + split handshakes.
  // lat = negedges from the first SEND sample to in_ack high (-1 on timeout).
  task automatic drive_flit(input logic [15:0] f, input int odly, input int sdly,
                            output logic [15:0] od, output logic sd, output logic req_ok,
                            output logic hold_ok, output int lat, output int rtz_lat,
                            output logic he);
    @(negedge clk);
    in_data = f; in_req = 1'b1;
    @(negedge clk);
    req_ok = (out_req === 1'b1) && (sel_req === 1'b1);
    od = out_data; sd = sel_data; he = hdr_err;
    hold_ok = 1'b1; lat = -1; rtz_lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (in_ack === 1'b1) begin
        lat = c;
        if (out_req !== 1'b0 || sel_req !== 1'b0) hold_ok = 1'b0;
        break;
      end
      if (out_req !== 1'b1 || sel_req !== 1'b1 || out_data !== od || sel_data !== sd)
        hold_ok = 1'b0;
      if (c == odly) out_ack = 1'b1;
      if (c == sdly) sel_ack = 1'b1;
    end
    in_req = 1'b0; out_ack = 1'b0; sel_ack = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (in_ack === 1'b0) begin
        rtz_lat = c;
        break;
      end
    end
  endtask

  // Driver: a flit expected to be dropped; samples outputs in the ack and release cycles.
  task automatic drive_drop(input logic [15:0] f, output logic ia1, output logic de1,
                            output logic req1, output logic [1:0] st1, output logic ia2,
                            output logic de2);
    @(negedge clk);
    in_data = f; in_req = 1'b1;
    @(negedge clk);
    ia1 = in_ack; de1 = drop_err; req1 = out_req | sel_req; st1 = dbg_state;
    in_req = 1'b0;
    @(negedge clk);
    ia2 = in_ack; de2 = drop_err;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if ({in_ack, out_req, sel_req, sel_data} !== 4'b0) $display("FAIL reset_ctl: got %b expected 0000", {in_ack, out_req, sel_req, sel_data}); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL reset_out_data: got %h expected 0000", out_data); else passed++;
    total++; if ({pkt_cnt0, pkt_cnt1} !== 16'h0) $display("FAIL reset_cnt: got %h expected 0000", {pkt_cnt0, pkt_cnt1}); else passed++;
    total++; if ({drop_err, hdr_err, busy, dbg_state} !== 5'b0) $display("FAIL reset_flags: got %b expected 00000", {drop_err, hdr_err, busy, dbg_state}); else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_eject();
    logic [15:0] od; logic sd, rq, hold, he; int lat, rl;
    drive_flit(16'hC120, 0, 0, od, sd, rq, hold, lat, rl, he);
    total++; if (rq !== 1'b1) $display("FAIL single_req: got %b expected 1", rq); else passed++;
    total++; if (od !== 16'hC120) $display("FAIL single_out_data: got %h expected c120", od); else passed++;
    total++; if (sd !== 1'b0) $display("FAIL single_sel: got %b expected 0", sd); else passed++;
    total++; if (lat != 1) $display("FAIL single_inack_lat: got %0d expected 1", lat); else passed++;
    total++; if (rl != 1) $display("FAIL single_rtz_lat: got %0d expected 1", rl); else passed++;
    total++; if (pkt_cnt0 !== 8'd1 || pkt_cnt1 !== 8'd0) $display("FAIL single_cnt: got %0d/%0d expected 1/0", pkt_cnt0, pkt_cnt1); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_three_flit();
    logic [15:0] od; logic sd, rq, hold, he; int lat, rl;
    logic [15:0] flits [3] = '{16'h8AB5, 16'h1234, 16'h4567};
    logic [7:0]  exp_c1 [3] = '{8'd0, 8'd0, 8'd1};
    foreach (flits[i]) exp_q.push_back(flits[i]);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp_f;
      drive_flit(flits[i], 1, 2, od, sd, rq, hold, lat, rl, he);
      exp_f = exp_q.pop_front();
      total++; if (od !== exp_f || sd !== 1'b1) $display("FAIL three_token%0d: got %h/%b expected %h/1", i, od, sd, exp_f); else passed++;
      total++; if (pkt_cnt1 !== exp_c1[i] || pkt_cnt0 !== 8'd1) $display("FAIL three_cnt%0d: got %0d/%0d expected 1/%0d", i, pkt_cnt0, pkt_cnt1, exp_c1[i]); else passed++;
      if (i == 0) begin
        total++; if (busy !== 1'b1) $display("FAIL three_busy_open: got %b expected 1", busy); else passed++;
      end
    end
  endtask

  task automatic test_ack_skew();
    logic [15:0] od; logic sd, rq, hold, he; int lat, rl;
    drive_flit(16'hC003, 0, 4, od, sd, rq, hold, lat, rl, he);
    total++; if (hold !== 1'b1) $display("FAIL skew_hold: got %b expected 1", hold); else passed++;
    total++; if (lat != 5) $display("FAIL skew_inack_lat: got %0d expected 5", lat); else passed++;
    total++; if (sd !== 1'b1 || pkt_cnt1 !== 8'd2) $display("FAIL skew_route_cnt: got %b/%0d expected 1/2", sd, pkt_cnt1); else passed++;
  endtask

  task automatic test_drop();
    logic ia1, de1, rq1, ia2, de2; logic [1:0] st1;
    drive_drop(16'h0042, ia1, de1, rq1, st1, ia2, de2);
    total++; if ({ia1, de1, rq1} !== 3'b110) $display("FAIL drop_ack_pulse: got %b expected 110", {ia1, de1, rq1}); else passed++;
    total++; if (st1 !== 2'd3) $display("FAIL drop_state: got %0d expected 3", st1); else passed++;
    total++; if ({ia2, de2} !== 2'b00) $display("FAIL drop_release: got %b expected 00", {ia2, de2}); else passed++;
    total++; if (pkt_cnt0 !== 8'd1 || pkt_cnt1 !== 8'd2) $display("FAIL drop_cnt: got %0d/%0d expected 1/2", pkt_cnt0, pkt_cnt1); else passed++;
  endtask

  task automatic test_hdr_err();
    logic [15:0] od; logic sd, rq, hold, he; int lat, rl;
    drive_flit(16'h8005, 0, 0, od, sd, rq, hold, lat, rl, he);
    total++; if (he !== 1'b0 || sd !== 1'b1) $display("FAIL hdr_first: got he=%b sel=%b expected 0/1", he, sd); else passed++;
    drive_flit(16'h8000, 0, 0, od, sd, rq, hold, lat, rl, he);
    total++; if (he !== 1'b1 || sd !== 1'b0) $display("FAIL hdr_second: got he=%b sel=%b expected 1/0", he, sd); else passed++;
    total++; if (hdr_err !== 1'b0) $display("FAIL hdr_pulse_width: got %b expected 0", hdr_err); else passed++;
    drive_flit(16'h4001, 0, 0, od, sd, rq, hold, lat, rl, he);
    total++; if (sd !== 1'b0 || he !== 1'b0) $display("FAIL hdr_tail: got sel=%b he=%b expected 0/0", sd, he); else passed++;
    total++; if (pkt_cnt0 !== 8'd2 || pkt_cnt1 !== 8'd2 || busy !== 1'b0) $display("FAIL hdr_cnt: got %0d/%0d busy=%b expected 2/2 busy=0", pkt_cnt0, pkt_cnt1, busy); else passed++;
  endtask

  task automatic test_wrap();
    logic [15:0] od; logic sd, rq, hold, he; int lat, rl;
    logic bad = 1'b0;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      drive_flit(16'hC001, 0, 0, od, sd, rq, hold, lat, rl, he);
      if (od !== 16'hC001 || sd !== 1'b1 || lat != 1 || rl != 1) bad = 1'b1;
      if (i == 255) begin
        total++; if (pkt_cnt1 !== 8'd0) $display("FAIL wrap_256: got %0d expected 0", pkt_cnt1); else passed++;
      end
    end
    total++; if (bad !== 1'b0) $display("FAIL wrap_tokens: got bad=%b expected 0", bad); else passed++;
    total++; if (pkt_cnt1 !== 8'd1 || pkt_cnt0 !== 8'd0) $display("FAIL wrap_257: got %0d/%0d expected 0/1", pkt_cnt0, pkt_cnt1); else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_data = 16'h8007; in_req = 1'b1;
    @(negedge clk);
    total++; if (out_req !== 1'b1 || dbg_state !== 2'd1) $display("FAIL mid_send: got req=%b st=%0d expected 1/1", out_req, dbg_state); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if ({in_ack, out_req, sel_req, sel_data, busy} !== 5'b0) $display("FAIL mid_ctl: got %b expected 00000", {in_ack, out_req, sel_req, sel_data, busy}); else passed++;
    total++; if (out_data !== 16'h0 || pkt_cnt1 !== 8'd0 || dbg_state !== 2'd0) $display("FAIL mid_data: got %h/%0d/%0d expected 0000/0/0", out_data, pkt_cnt1, dbg_state); else passed++;
    in_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if ({out_req, busy, dbg_state} !== 4'b0) $display("FAIL mid_after: got %b expected 0000", {out_req, busy, dbg_state}); else passed++;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_eject();
    test_three_flit();
    test_ack_skew();
    test_drop();
    test_hdr_err();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
